instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address after reset.
REQ-002 Parameter: NOP, 32'h0000_0033, instruction value driven on instr_o when no valid instruction is held.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  downstream IF/ID register cannot accept; hold the current output.
REQ-006 redirect_valid  input  1  branch/jump taken; restart fetch at redirect_pc.
REQ-007 redirect_pc  input  32  redirect target address.
REQ-008 imem_req  output  1  instruction-memory request valid.
REQ-009 imem_addr  output  32  request address, word aligned.
REQ-010 imem_gnt  input  1  memory accepts the request this cycle.
REQ-011 imem_rvalid  input  1  response data valid.
REQ-012 imem_rdata  input  32  response instruction.
REQ-013 pc_o  output  32  PC of the instruction on instr_o.
REQ-014 instr_o  output  32  fetched instruction to IF/ID.
REQ-015 valid_o  output  1  pc_o/instr_o hold a valid instruction.
REQ-016 flush_o  output  1  combinational copy of redirect_valid, driven to IF/ID flush.

Function
REQ-017 FSM states SHALL be REQ (request pending), WAIT (one request outstanding), DRAIN (outstanding response to discard).
REQ-018 At most one request SHALL be outstanding; imem_req SHALL be asserted only in REQ, when redirect_valid=0, and when not (valid_o=1 and stall=1).
REQ-019 imem_addr SHALL equal the fetch_pc register; bits [1:0] are always 0.
REQ-020 REQ with imem_req=1 and imem_gnt=1: latch req_pc<=fetch_pc, go to WAIT.
REQ-021 WAIT with imem_rvalid=1: instr_o<=imem_rdata, pc_o<=req_pc, valid_o<=1, fetch_pc<=req_pc+4 (mod 2^32), go to REQ; minimum latency grant-to-valid_o is one cycle after rvalid.
REQ-022 valid_o=1 and stall=1: pc_o, instr_o, and valid_o SHALL hold unchanged.
REQ-023 valid_o=1, stall=0, no capture that cycle: valid_o<=0, instr_o<=NOP.
REQ-024 redirect_valid=1 SHALL take priority over every other event: fetch_pc<={redirect_pc[31:2],2'b00}; valid_o<=0; instr_o<=NOP; any rvalid that cycle is discarded.
REQ-025 Next state on redirect: WAIT with rvalid=0 -> DRAIN; WAIT with rvalid=1 -> REQ; otherwise -> REQ.
REQ-026 DRAIN with imem_rvalid=1: discard the data and go to REQ; a further redirect in DRAIN updates only fetch_pc.
REQ-027 An rvalid outside WAIT and DRAIN SHALL be ignored.
REQ-028 A response arriving in WAIT while stalled cannot occur by REQ-018, so no overflow path exists.

Reset
REQ-029 While rst=0, asynchronously: state=REQ, fetch_pc=RESET_PC, req_pc=RESET_PC, pc_o=0, instr_o=NOP, valid_o=0.
REQ-030 Reset asserted mid-request SHALL abandon the outstanding transaction; the first request after release SHALL be RESET_PC.
REQ-031 imem_req SHALL be 0 while rst=0, and may first assert in the first cycle after release.

Verification
REQ-032 Reset release with imem_gnt=1 and rvalid one cycle after each grant -> addresses 0x0, 0x4, 0x8; pc_o/instr_o pairs match, valid_o=1 per capture.
REQ-033 stall=1 for 3 cycles while valid_o=1 -> outputs frozen and imem_req=0; stall drops -> next request issues at pc_o+4.
REQ-034 redirect_valid=1 with redirect_pc=0x103 in WAIT, rvalid next cycle -> flush_o=1 same cycle, that response discarded, next imem_addr=0x100.
REQ-035 Redirect coincident with rvalid in WAIT -> data discarded, valid_o=0, immediate request at redirect target.
REQ-036 fetch_pc=0xFFFF_FFFC captured -> next imem_addr=0x0000_0000.
REQ-037 rst asserted in WAIT, then released -> imem_addr=RESET_PC, and a stale rvalid arriving in REQ is ignored.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with a single outstanding memory request
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0033
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o,
    output logic        flush_o
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic        capture;
    logic        grant;

    assign imem_addr = fetch_pc;
    assign flush_o   = redirect_valid;

    always_comb begin
        state_next = state;
        imem_req   = rst && (state == S_REQ) && !redirect_valid && !(valid_o && stall);
        grant      = imem_req && imem_gnt;
        capture    = (state == S_WAIT) && imem_rvalid && !redirect_valid;
        case (state)
            S_REQ: begin
                if (grant) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid) state_next = imem_rvalid ? S_REQ : S_DRAIN;
                else if (imem_rvalid) state_next = S_REQ;
            end
            S_DRAIN: begin
                // A redirect here must not leave DRAIN: the old response is still in flight.
                if (imem_rvalid) state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC & ALIGN_MASK;
            req_pc   <= RESET_PC & ALIGN_MASK;
            pc_o     <= 32'h0;
            instr_o  <= NOP;
            valid_o  <= 1'b0;
        end else begin
            state <= state_next;

            if (redirect_valid)
                fetch_pc <= redirect_pc & ALIGN_MASK;
            else if (capture)
                fetch_pc <= req_pc + 32'd4;

            if (grant)
                req_pc <= fetch_pc;

            if (redirect_valid) begin
                if (state != S_DRAIN) begin
                    valid_o <= 1'b0;
                    instr_o <= NOP;
                end
            end else if (capture) begin
                valid_o <= 1'b1;
                pc_o    <= req_pc;
                instr_o <= imem_rdata;
            end else if (valid_o && !stall) begin
                valid_o <= 1'b0;
                instr_o <= NOP;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and randomized self-checking bench for instr_fetch
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0033;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;
    logic        flush_o;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: next address to fetch, the one request in
    // flight (and whether it has been cancelled), and the instruction slot.
    logic [31:0] m_next;
    logic        m_busy;
    logic [31:0] m_busy_pc;
    logic        m_discard;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    instr_fetch #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .pc_o           (pc_o),
        .instr_o        (instr_o),
        .valid_o        (valid_o),
        .flush_o        (flush_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_next    = RESET_PC;
        m_busy    = 1'b0;
        m_busy_pc = RESET_PC;
        m_discard = 1'b0;
        m_valid   = 1'b0;
        m_pc      = 32'h0;
        m_instr   = NOP;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0;
        #1;
        chk("rst_req",   {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, valid_o},  32'h0);
        chk("rst_instr", instr_o,           NOP);
        chk("rst_pc",    pc_o,              32'h0);
        chk("rst_addr",  imem_addr,         RESET_PC);
        @(posedge clk);
        #1;
        chk("rst_req_hold", {31'b0, imem_req}, 32'h0);
        model_reset();
        @(negedge clk);
        imem_gnt = 1'b0;
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input logic g, input logic st, input logic rd, input logic [31:0] rp,
                        input logic rv, input logic [31:0] data);
        logic exp_req;
        logic captured;
        @(negedge clk);
        imem_gnt = g; stall = st; redirect_valid = rd; redirect_pc = rp;
        imem_rvalid = rv; imem_rdata = data;
        #1;
        exp_req = !rd && !m_busy && !(m_valid && st);
        chk("req",   {31'b0, imem_req}, {31'b0, exp_req});
        chk("addr",  imem_addr,         m_next);
        chk("flush", {31'b0, flush_o},  {31'b0, rd});
        chk("valid", {31'b0, valid_o},  {31'b0, m_valid});
        chk("pc",    pc_o,              m_pc);
        chk("instr", instr_o,           m_instr);

        captured = 1'b0;
        if (rd) begin
            m_next  = {rp[31:2], 2'b00};
            m_valid = 1'b0;
            m_instr = NOP;
            if (m_busy && !rv) m_discard = 1'b1;
            else if (m_busy) m_busy = 1'b0;
        end else begin
            if (m_busy && rv) begin
                if (!m_discard) begin
                    captured = 1'b1;
                    m_valid  = 1'b1;
                    m_pc     = m_busy_pc;
                    m_instr  = data;
                    m_next   = m_busy_pc + 32'd4;
                end
                m_busy = 1'b0;
            end
            if (!captured && m_valid && !st) begin
                m_valid = 1'b0;
                m_instr = NOP;
            end
            if (exp_req && g) begin
                m_busy    = 1'b1;
                m_busy_pc = m_next;
                m_discard = 1'b0;
            end
        end
    endtask

    initial begin
        model_reset();
        do_reset();

        // Back-to-back fetches 0x0, 0x4, 0x8 with one-cycle memory latency.
        step(1, 0, 0, 0, 0, 0);
        chk("seq_addr0", imem_addr, 32'h0);
        step(1, 0, 0, 0, 1, 32'hA000_0001);
        step(1, 0, 0, 0, 0, 0);
        chk("seq_pc0",    pc_o,    32'h0);
        chk("seq_instr0", instr_o, 32'hA000_0001);
        chk("seq_addr1",  imem_addr, 32'h4);
        step(1, 0, 0, 0, 1, 32'hA000_0002);
        step(1, 0, 0, 0, 0, 0);
        chk("seq_pc1",    pc_o,    32'h4);
        chk("seq_instr1", instr_o, 32'hA000_0002);
        chk("seq_addr2",  imem_addr, 32'h8);
        step(1, 0, 0, 0, 1, 32'hA000_0003);

        // Stall holds the output and blocks new requests.
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0, 0);
            chk("stall_valid", {31'b0, valid_o}, 32'h1);
            chk("stall_pc",    pc_o,    32'h8);
            chk("stall_instr", instr_o, 32'hA000_0003);
            chk("stall_req",   {31'b0, imem_req}, 32'h0);
        end
        step(0, 0, 0, 0, 0, 0);
        chk("unstall_req",  {31'b0, imem_req}, 32'h1);
        chk("unstall_addr", imem_addr, 32'hC);

        // Redirect while waiting; the late response is dropped.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h103, 0, 0);
        chk("redir_flush", {31'b0, flush_o}, 32'h1);
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("drain_req", {31'b0, imem_req}, 32'h0);
        step(0, 0, 0, 0, 0, 0);
        chk("redir_addr",  imem_addr, 32'h100);
        chk("redir_valid", {31'b0, valid_o}, 32'h0);

        // Redirect coincident with the response.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h200, 1, 32'hBAD0_0001);
        step(0, 0, 0, 0, 0, 0);
        chk("coinc_valid", {31'b0, valid_o}, 32'h0);
        chk("coinc_instr", instr_o, NOP);
        chk("coinc_req",   {31'b0, imem_req}, 32'h1);
        chk("coinc_addr",  imem_addr, 32'h200);

        // Address wrap at the top of memory.
        step(0, 0, 1, 32'hFFFF_FFFE, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1, 32'h1234_5678);
        step(0, 1, 0, 0, 0, 0);
        chk("wrap_pc",   pc_o, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset in WAIT, then a stale response after release.
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 1, 32'h5151_5151);
        chk("post_rst_addr", imem_addr, RESET_PC);
        chk("post_rst_req",  {31'b0, imem_req}, 32'h1);
        step(0, 0, 0, 0, 0, 0);
        chk("stale_valid", {31'b0, valid_o}, 32'h0);
        chk("stale_instr", instr_o, NOP);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            logic g, st, rd, rv;
            logic [31:0] rp, data;
            g    = ($urandom % 2) == 0;
            st   = ($urandom % 3) == 0;
            rd   = ($urandom % 9) == 0;
            rp   = $urandom;
            rv   = m_busy ? (($urandom % 2) == 0) : (($urandom % 16) == 0);
            data = $urandom;
            step(g, st, rd, rp, rv, data);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
